// File: rtl/aibcr3_signal_buf_filt.sv
// ---------------------------------------------------------------------------
// aibcr3_signal_buf_filt
//
// Multi-channel signal conditioner for slow or asynchronous AIB sideband and
// configuration inputs. Each channel is synchronised into the clk domain
// through a STAGES-deep flop chain and then passed through a deglitch filter
// that only accepts a new level after it has been stable for FILT_LEN
// consecutive clock edges. Any channel can be bypassed, in which case its
// output follows the raw input combinationally while the synchroniser and
// filter keep running underneath.
//
// Parameters:
//   WIDTH    number of independent channels
//   STAGES   synchroniser flops per channel (1..4)
//   FILT_LEN stable edges required before the filtered value updates (1..15)
//   RST_VAL  reset value of the sync chain, filtered register and the
//            non-bypassed outputs
//
// Ports:
//   clk      sampling clock
//   rst      asynchronous, active-high reset
//   vcc      supply pin, no functional effect
//   vssl     ground pin, no functional effect
//   sig_in   raw channel inputs, may be asynchronous to clk
//   byp_en   per-channel bypass, 1 = sig_out[i] follows sig_in[i]
//   filt_en  global filter enable, quasi-static and synchronous to clk
//   sig_out  buffered / filtered channel outputs
//   sig_chg  one-cycle pulse when any non-bypassed filtered value changes
// ---------------------------------------------------------------------------
module aibcr3_signal_buf_filt #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      STAGES   = 2,
  parameter int unsigned      FILT_LEN = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vcc,
  input  logic             vssl,
  input  logic [WIDTH-1:0] sig_in,
  input  logic [WIDTH-1:0] byp_en,
  input  logic             filt_en,
  output logic [WIDTH-1:0] sig_out,
  output logic             sig_chg
);

  // Counter must hold 0..FILT_LEN-1; sized from FILT_LEN+1 so FILT_LEN=1
  // still gets a legal one-bit vector.
  localparam int unsigned      CNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  // Supply pins are kept on the port list for netlist compatibility only.
  logic unused_supply_s;
  assign unused_supply_s = vcc ^ vssl;

  logic [WIDTH-1:0]       sync_r [STAGES];
  logic [WIDTH-1:0]       s_s;
  logic [WIDTH-1:0]       f_r;
  logic [WIDTH-1:0]       f_nxt_s;
  logic [WIDTH-1:0]       chg_mask_s;
  logic                   sig_chg_r;
  logic [WIDTH*CNT_W-1:0] cnt_flat_s;

  // Synchroniser chain: stage 0 samples the raw input, the last stage feeds
  // the filter. Every stage resets to RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= RST_VAL;
      end
    end else begin
      sync_r[0] <= sig_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign s_s = sync_r[STAGES-1];

  // Per-channel deglitch counter. The counter tracks how many consecutive
  // edges the synchronised value has disagreed with the filtered value; it
  // saturates at FILT_LEN-1, at which point the next disagreeing edge
  // commits the new level and restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             f_bit_nxt_s;

    // Next-state decode for this channel's counter and filtered bit.
    always_comb begin
      cnt_nxt_s   = {CNT_W{1'b0}};
      f_bit_nxt_s = f_r[i];
      if (!filt_en) begin
        // Filter disabled: follow the synchroniser, counter parked at zero.
        f_bit_nxt_s = s_s[i];
      end else if (s_s[i] == f_r[i]) begin
        // Agreement drops any partial glitch count.
        cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r >= CNT_MAX) begin
        // Stable long enough: accept the new level.
        f_bit_nxt_s = s_s[i];
        cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      end
    end

    // Counter register for this channel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_nxt_s;
      end
    end

    assign f_nxt_s[i]                       = f_bit_nxt_s;
    assign cnt_flat_s[i*CNT_W +: CNT_W]     = cnt_r;
  end

  // Only channels that are not bypassed can raise the change pulse, since a
  // bypassed channel's filtered value is not visible on sig_out.
  assign chg_mask_s = (f_nxt_s ^ f_r) & ~byp_en;

  // Filtered value register and change pulse; both update on the same edge
  // so the pulse lines up with the new value on sig_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_r       <= RST_VAL;
      sig_chg_r <= 1'b0;
    end else begin
      f_r       <= f_nxt_s;
      sig_chg_r <= |chg_mask_s;
    end
  end

  // Output mux is combinational on purpose: bypassed channels must pass
  // sig_in straight through, including while rst is asserted.
  assign sig_out = (byp_en & sig_in) | (~byp_en & f_r);
  assign sig_chg = sig_chg_r;

  aibcr3_signal_buf_filt_chk #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .FILT_LEN(FILT_LEN)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .filt_en (filt_en),
    .cnt_flat(cnt_flat_s)
  );

endmodule

// ---------------------------------------------------------------------------
// aibcr3_signal_buf_filt_chk
//
// Property checker for the deglitch counters: a counter never passes
// FILT_LEN-1 and is forced back to zero one edge after the filter is
// disabled.
//
// Ports:
//   clk       sampling clock
//   rst       asynchronous, active-high reset (disables the properties)
//   filt_en   global filter enable
//   cnt_flat  all channel counters, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module aibcr3_signal_buf_filt_chk #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned FILT_LEN = 3
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   filt_en,
  input logic [WIDTH*CNT_W-1:0] cnt_flat
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chk
    logic [CNT_W-1:0] cnt_s;
    assign cnt_s = cnt_flat[i*CNT_W +: CNT_W];

    a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
      cnt_s <= CNT_MAX);

    a_cnt_clear : assert property (@(posedge clk) disable iff (rst)
      !filt_en |=> (cnt_s == {CNT_W{1'b0}}));
  end

endmodule

// File: tb/tb_aibcr3_signal_buf_filt.sv
// ---------------------------------------------------------------------------
// tb_aibcr3_signal_buf_filt
//
// Bench for aibcr3_signal_buf_filt with WIDTH=8, STAGES=2, FILT_LEN=3,
// RST_VAL=0. Expected outputs are queued as stimulus is applied and
// compared by an independent monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aibcr3_signal_buf_filt;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned STAGES   = 2;
  localparam int unsigned FILT_LEN = 3;
  localparam logic [7:0]  RST_VAL  = 8'h00;

  logic       clk;
  logic       rst;
  logic       vcc;
  logic       vssl;
  logic [7:0] sig_in;
  logic [7:0] byp_en;
  logic       filt_en;
  logic [7:0] sig_out;
  logic       sig_chg;

  aibcr3_signal_buf_filt #(
    .WIDTH   (WIDTH),
    .STAGES  (STAGES),
    .FILT_LEN(FILT_LEN),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vcc    (vcc),
    .vssl   (vssl),
    .sig_in (sig_in),
    .byp_en (byp_en),
    .filt_en(filt_en),
    .sig_out(sig_out),
    .sig_chg(sig_chg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       chg;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   passes = 0;

  // ---------------- reference model ----------------
  logic [7:0] hist_q[$];      // sampled inputs, newest first
  logic [7:0] f_m;
  int         run_m[8];       // consecutive disagreeing edges per channel
  logic       chg_m;

  task automatic model_reset();
    hist_q.delete();
    for (int k = 0; k < STAGES; k++) hist_q.push_back(RST_VAL);
    f_m   = RST_VAL;
    chg_m = 1'b0;
    for (int c = 0; c < 8; c++) run_m[c] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] s;
    logic [7:0] f_new;
    s     = hist_q[STAGES-1];
    f_new = f_m;
    for (int c = 0; c < 8; c++) begin
      if (!filt_en) begin
        f_new[c] = s[c];
        run_m[c] = 0;
      end else if (s[c] == f_m[c]) begin
        run_m[c] = 0;
      end else begin
        run_m[c] = run_m[c] + 1;
        if (run_m[c] == FILT_LEN) begin
          f_new[c] = s[c];
          run_m[c] = 0;
        end
      end
    end
    chg_m = |((f_new ^ f_m) & ~byp_en);
    f_m   = f_new;
    hist_q.push_front(sig_in);
    void'(hist_q.pop_back());
  endtask

  function automatic logic [7:0] model_out();
    return (byp_en & sig_in) | (~byp_en & f_m);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [7:0] o, input logic c, input string tag);
    exp_t e;
    e.out = o;
    e.chg = c;
    e.tag = tag;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  task automatic drive_edge(input logic [7:0] in_v, input logic [7:0] byp_v, input logic fe_v);
    @(negedge clk);
    sig_in  = in_v;
    byp_en  = byp_v;
    filt_en = fe_v;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_edge();
  endtask

  task automatic step_c(input logic [7:0] in_v, input logic [7:0] byp_v, input logic fe_v,
                        input logic [7:0] o, input logic c, input string tag);
    drive_edge(in_v, byp_v, fe_v);
    push_exp(o, c, tag);
  endtask

  task automatic step_m(input logic [7:0] in_v, input logic [7:0] byp_v, input logic fe_v,
                        input string tag);
    drive_edge(in_v, byp_v, fe_v);
    push_exp(model_out(), chg_m, tag);
  endtask

  // ---------------- monitor ----------------
  always begin
    exp_t e;
    @(chk_ev);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL queue_underflow actual=empty required=entry");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (sig_out === e.out) passes++;
      else $display("FAIL %s sig_out actual=%h required=%h t=%0t", e.tag, sig_out, e.out, $time);
      checks++;
      if (sig_chg === e.chg) passes++;
      else $display("FAIL %s sig_chg actual=%b required=%b t=%0t", e.tag, sig_chg, e.chg, $time);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] r_in;
    logic [7:0] r_byp;
    logic       r_fe;
    int         rst_left;

    vcc     = 1'b1;
    vssl    = 1'b0;
    rst     = 1'b1;
    sig_in  = 8'hFF;
    byp_en  = 8'h00;
    filt_en = 1'b0;
    model_reset();

    // 1. reset holds outputs at RST_VAL, bypass passes through during reset
    step_c(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, "rst_hold0");
    step_c(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, "rst_hold1");
    #3;
    byp_en = 8'h01;
    #1;
    push_exp(8'h01, 1'b0, "rst_bypass_now");
    step_c(8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, "rst_bypass_edge");
    step_c(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "rst_clear_in");
    #3;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step_c(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "idle");

    // 2. unfiltered latency STAGES+1
    step_c(8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, "unf_e0");
    step_c(8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, "unf_e1");
    step_c(8'h5A, 8'h00, 1'b0, 8'h5A, 1'b1, "unf_e2");
    step_c(8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, "unf_e3");
    for (int k = 0; k < 4; k++) step_m(8'h00, 8'h00, 1'b0, "unf_back");

    // 3. glitch of FILT_LEN-1 cycles is dropped
    step_m(8'h00, 8'h00, 1'b1, "filt_on");
    step_m(8'h00, 8'h00, 1'b1, "filt_on");
    step_c(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, "glitch_hi");
    step_c(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, "glitch_hi");
    for (int k = 0; k < 5; k++) step_c(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "glitch_lo");

    // 4. stable input accepted after STAGES+FILT_LEN edges, both directions
    for (int k = 0; k < 4; k++) step_c(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, "acc_rise_wait");
    step_c(8'h01, 8'h00, 1'b1, 8'h01, 1'b1, "acc_rise_e4");
    step_c(8'h01, 8'h00, 1'b1, 8'h01, 1'b0, "acc_rise_e5");
    for (int k = 0; k < 4; k++) step_c(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "acc_fall_wait");
    step_c(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "acc_fall_e4");
    step_c(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "acc_fall_e5");

    // 5. asynchronous reset mid-count, then fresh start
    for (int k = 0; k < 3; k++) step_c(8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, "mid_cnt");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    push_exp(8'h00, 1'b0, "async_rst_now");
    step_c(8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, "in_rst");
    step_c(8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, "in_rst");
    #3;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step_c(8'h0F, 8'h00, 1'b1, 8'h00, 1'b0, "post_rst_wait");
    step_c(8'h0F, 8'h00, 1'b1, 8'h0F, 1'b1, "post_rst_e4");
    step_c(8'h0F, 8'h00, 1'b1, 8'h0F, 1'b0, "post_rst_e5");

    // 6. bypassed channels never pulse sig_chg
    for (int k = 0; k < 4; k++) step_m(8'h00, 8'h00, 1'b0, "pre_byp");
    for (int k = 0; k < 5; k++) step_c(8'hA0, 8'hF0, 1'b0, 8'hA0, 1'b0, "byp_mask");
    for (int k = 0; k < 3; k++) step_c(8'hA0, 8'h00, 1'b0, 8'hA0, 1'b0, "byp_clear");

    // randomized traffic against the model
    r_in     = 8'hA0;
    r_byp    = 8'h00;
    r_fe     = 1'b1;
    rst_left = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r_in = r_in ^ 8'($urandom);
      if ($urandom_range(0, 19) == 0) r_byp = 8'($urandom);
      if ($urandom_range(0, 39) == 0) r_fe = ~r_fe;
      step_m(r_in, r_byp, r_fe, "rand");
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) begin
          #3;
          rst = 1'b0;
        end
      end else if ($urandom_range(0, 59) == 0) begin
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        push_exp(model_out(), 1'b0, "rand_async_rst");
        rst_left = $urandom_range(1, 3);
      end
    end

    #5;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL queue_drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
